// File: rtl/sat_counter_table.sv
// sat_counter_table: table of ENTRIES saturating up/down counters with a
// registered lookup port and an update port. After reset, a sweep writes
// INIT_VALUE into every entry before the table reports ready.
// Optional feature macro: SAT_COUNTER_TABLE_BYPASS_EN. When it is defined,
// a lookup and an update to the same index in the same cycle return the
// post-update value. When it is undefined, they return the pre-update value.
module sat_counter_table #(
   parameter  int unsigned ENTRIES     = 1024,
   parameter  int unsigned CTR_WIDTH   = 2,
   parameter  int unsigned INIT_VALUE  = 0,
   localparam int unsigned INDEX_WIDTH = $clog2(ENTRIES)
) (
   input  logic                   clock,
   input  logic                   reset,
   output logic                   ready,
   input  logic                   lookup_valid,
   input  logic [INDEX_WIDTH-1:0] lookup_index,
   output logic                   pred_valid,
   output logic                   pred_taken,
   output logic [CTR_WIDTH-1:0]   pred_counter,
   input  logic                   update_valid,
   input  logic [INDEX_WIDTH-1:0] update_index,
   input  logic                   update_taken
);

   localparam logic [CTR_WIDTH-1:0]   CTR_MAX    = '1;
   localparam logic [CTR_WIDTH-1:0]   CTR_INIT   = CTR_WIDTH'(INIT_VALUE);
   localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(ENTRIES - 1);

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [INDEX_WIDTH-1:0] sweep_ptr;
   logic [INDEX_WIDTH-1:0] sweep_ptr_next;

   logic [CTR_WIDTH-1:0]   counters [ENTRIES];

   logic                   lookup_fire;
   logic                   update_fire;
   logic [CTR_WIDTH-1:0]   update_old;
   logic [CTR_WIDTH-1:0]   update_new;
   logic [CTR_WIDTH-1:0]   read_value;
   logic                   write_en;
   logic [INDEX_WIDTH-1:0] write_index;
   logic [CTR_WIDTH-1:0]   write_data;

   // State and sweep pointer registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= INIT;
         sweep_ptr <= '0;
      end else begin
         state     <= state_next;
         sweep_ptr <= sweep_ptr_next;
      end
   end

   // Next state: the sweep visits every entry once, then the table runs until reset
   always_comb begin
      state_next     = state;
      sweep_ptr_next = sweep_ptr;
      case (state)
         INIT: begin
            sweep_ptr_next = sweep_ptr + INDEX_WIDTH'(1);
            if (sweep_ptr == LAST_INDEX) begin
               state_next = RUN;
            end
         end
         RUN:     state_next = RUN;
         default: state_next = INIT;
      endcase
   end

   // Request qualification and saturating next value for the update port
   always_comb begin
      lookup_fire = ready & lookup_valid & ~reset;
      update_fire = ready & update_valid & ~reset;
      update_old  = counters[update_index];
      if (update_taken) begin
         update_new = (update_old == CTR_MAX) ? update_old : update_old + CTR_WIDTH'(1);
      end else begin
         update_new = (update_old == '0) ? update_old : update_old - CTR_WIDTH'(1);
      end
   end

   // Lookup read path, with optional forwarding of a same-index update
   always_comb begin
      read_value = counters[lookup_index];
`ifdef SAT_COUNTER_TABLE_BYPASS_EN
      if (update_fire && (update_index == lookup_index)) begin
         read_value = update_new;
      end
`endif
   end

   // Single write port: the sweep owns it during INIT and the update port owns it afterwards
   always_comb begin
      write_en    = 1'b0;
      write_index = update_index;
      write_data  = update_new;
      if (!reset) begin
         if (state == INIT) begin
            write_en    = 1'b1;
            write_index = sweep_ptr;
            write_data  = CTR_INIT;
         end else if (update_fire) begin
            write_en = 1'b1;
         end
      end
   end

   // Counter storage; the reset sweep clears it, so the array itself has no reset
   always_ff @(posedge clock) begin
      if (write_en) begin
         counters[write_index] <= write_data;
      end
   end

   // Registered outputs; the prediction holds its value when no lookup fires
   always_ff @(posedge clock) begin
      if (reset) begin
         ready        <= 1'b0;
         pred_valid   <= 1'b0;
         pred_taken   <= 1'b0;
         pred_counter <= '0;
      end else begin
         ready      <= (state == RUN);
         pred_valid <= lookup_fire;
         if (lookup_fire) begin
            pred_counter <= read_value;
            pred_taken   <= read_value[CTR_WIDTH-1];
         end
      end
   end

endmodule

// File: tb/tb_sat_counter_table.sv
// tb_sat_counter_table: directed, table-driven bench for sat_counter_table
// with ENTRIES=16, CTR_WIDTH=2 and INIT_VALUE=1.
module tb_sat_counter_table;

   localparam int unsigned ENTRIES    = 16;
   localparam int unsigned CTR_WIDTH  = 2;
   localparam int unsigned INIT_VALUE = 1;

`ifdef SAT_COUNTER_TABLE_BYPASS_EN
   localparam int COLLIDE_EXP = 2;
`else
   localparam int COLLIDE_EXP = 1;
`endif

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic                 ready;
   logic                 lookup_valid = 1'b1;
   logic [3:0]           lookup_index = 4'd0;
   logic                 pred_valid;
   logic                 pred_taken;
   logic [CTR_WIDTH-1:0] pred_counter;
   logic                 update_valid = 1'b0;
   logic [3:0]           update_index = 4'd0;
   logic                 update_taken = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       lv;
      logic [3:0] li;
      logic       uv;
      logic [3:0] ui;
      logic       ut;
      logic       pv;
      logic [1:0] pc;
   } vec_t;

   vec_t       vecs[$];
   logic [1:0] last_pc;

   sat_counter_table #(
      .ENTRIES   (ENTRIES),
      .CTR_WIDTH (CTR_WIDTH),
      .INIT_VALUE(INIT_VALUE)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .ready       (ready),
      .lookup_valid(lookup_valid),
      .lookup_index(lookup_index),
      .pred_valid  (pred_valid),
      .pred_taken  (pred_taken),
      .pred_counter(pred_counter),
      .update_valid(update_valid),
      .update_index(update_index),
      .update_taken(update_taken)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic add_upd(input int idx, input int taken);
      vecs.push_back('{1'b0, 4'd0, 1'b1, 4'(idx), 1'(taken), 1'b0, 2'd0});
   endtask

   task automatic add_lk(input int idx, input int exp);
      vecs.push_back('{1'b1, 4'(idx), 1'b0, 4'd0, 1'b0, 1'b1, 2'(exp)});
   endtask

   // Follows the first edge after reset release: ENTRIES edges with ready low, then ready high
   task automatic sweep_check(input string tag);
      for (int i = 1; i <= int'(ENTRIES); i++) begin
         tick;
         check($sformatf("%s ready low edge %0d", tag, i), ready, 0);
         check($sformatf("%s pred_valid low edge %0d", tag, i), pred_valid, 0);
      end
      tick;
      check($sformatf("%s ready high", tag), ready, 1);
      check($sformatf("%s pred_valid before first lookup", tag), pred_valid, 0);
   endtask

   initial begin
      int up_exp[5]   = '{1, 2, 3, 3, 3};
      int down_exp[5] = '{2, 1, 0, 0, 0};

      // Reset for two cycles with lookup_valid held high
      tick;
      tick;
      check("reset ready", ready, 0);
      check("reset pred_valid", pred_valid, 0);
      check("reset pred_counter", pred_counter, 0);
      check("reset pred_taken", pred_taken, 0);
      reset = 1'b0;
      sweep_check("init");

      // Every entry reads INIT_VALUE, one lookup per cycle
      for (int i = 0; i < int'(ENTRIES); i++) begin
         lookup_index = 4'(i);
         tick;
         check($sformatf("init read %0d pred_valid", i), pred_valid, 1);
         check($sformatf("init read %0d pred_counter", i), pred_counter, 1);
         check($sformatf("init read %0d pred_taken", i), pred_taken, 0);
      end
      last_pc = 2'd1;

      // Vector table: saturation, independence, back-to-back lookups
      add_upd(7, 0);
      for (int k = 0; k < 5; k++) begin
         add_upd(7, 1);
         add_lk(7, up_exp[k]);
      end
      for (int k = 0; k < 5; k++) begin
         add_upd(7, 0);
         add_lk(7, down_exp[k]);
      end
      vecs.push_back('{1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b1, 2'd1});
      add_lk(6, 2);
      add_upd(0, 0);
      add_upd(1, 1);
      add_upd(2, 1);
      add_upd(2, 1);
      add_lk(0, 0);
      add_lk(1, 2);
      add_lk(2, 3);
      add_lk(3, 1);

      foreach (vecs[i]) begin
         lookup_valid = vecs[i].lv;
         lookup_index = vecs[i].li;
         update_valid = vecs[i].uv;
         update_index = vecs[i].ui;
         update_taken = vecs[i].ut;
         tick;
         if (vecs[i].pv) last_pc = vecs[i].pc;
         check($sformatf("vec%0d pred_valid", i), pred_valid, int'(vecs[i].pv));
         check($sformatf("vec%0d pred_counter", i), pred_counter, int'(last_pc));
         check($sformatf("vec%0d pred_taken", i), pred_taken, int'(last_pc[1]));
      end

      // Same-index lookup and update in one cycle; entry 4 still holds 1
      lookup_valid = 1'b1;
      lookup_index = 4'd4;
      update_valid = 1'b1;
      update_index = 4'd4;
      update_taken = 1'b1;
      tick;
      check("collide pred_valid", pred_valid, 1);
      check("collide pred_counter", pred_counter, COLLIDE_EXP);
      check("collide pred_taken", pred_taken, COLLIDE_EXP / 2);
      update_valid = 1'b0;
      tick;
      check("after collide pred_counter", pred_counter, 2);
      check("after collide pred_taken", pred_taken, 1);

      // Bring entry 3 from 1 to 3
      lookup_valid = 1'b0;
      update_valid = 1'b1;
      update_index = 4'd3;
      update_taken = 1'b1;
      tick;
      tick;
      update_valid = 1'b0;
      lookup_valid = 1'b1;
      lookup_index = 4'd3;
      tick;
      check("pre-reset entry3", pred_counter, 3);

      // One reset cycle with both request types active
      reset        = 1'b1;
      update_valid = 1'b1;
      update_taken = 1'b0;
      tick;
      check("midreset pred_valid", pred_valid, 0);
      check("midreset ready", ready, 0);
      check("midreset pred_counter", pred_counter, 0);
      reset        = 1'b0;
      update_valid = 1'b0;
      sweep_check("resweep");
      tick;
      check("resweep entry3 pred_valid", pred_valid, 1);
      check("resweep entry3 pred_counter", pred_counter, int'(INIT_VALUE));
      check("resweep entry3 pred_taken", pred_taken, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
